avmm_reg_bank: RTL and testbench

Parametrised Avalon-MM slave register bank for the board test tops. A host such as the JTAG-to-Avalon master (vjtag_mm) reads and writes NUM_REGS byte-enabled control registers. It can also read NUM_STATUS read-only status words. Read latency is fixed and configurable and is signalled with readdatavalid. Register contents are exported flat to the fabric (LEDs, test logic), and each register has a one-cycle write strobe.

---
 rtl/avmm_reg_pkg.sv | 18 +
 rtl/avmm_rd_pipe.sv | 35 +++
 rtl/avmm_reg_bank.sv | 105 ++++++++++
 tb/tb_avmm_reg_bank.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/avmm_reg_pkg.sv
// Shared constants and sizing helpers for the Avalon-MM register bank.
package avmm_reg_pkg;

    localparam logic [31:0] AVMM_DEFAULT_RDATA = 32'hDEADBEEF;

    // Width needed to index n words; never less than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic int lane_cnt(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/avmm_rd_pipe.sv
// Fixed-latency read response pipeline: per-stage valid bit and data word.
module avmm_rd_pipe #(
    parameter int LATENCY = 1,
    parameter int DATA_W  = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]  dat_q [LATENCY];

    // Data stages only advance behind a valid bit so the output holds between responses.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) dat_q[k] <= '0;
        end else begin
            vld_q[0] <= in_valid;
            if (in_valid) dat_q[0] <= in_data;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/avmm_reg_bank.sv
// Avalon-MM slave with byte-enabled control registers, read-only status words
// and a fixed read latency.
module avmm_reg_bank
    import avmm_reg_pkg::*;
#(
    parameter int                NUM_REGS      = 4,
    parameter int                NUM_STATUS    = 0,
    parameter int                DATA_W        = 32,
    parameter int                ADDR_W        = 32,
    parameter int                READ_LATENCY  = 1,
    parameter logic [DATA_W-1:0] RESET_VAL     = '0,
    parameter logic [DATA_W-1:0] DEFAULT_RDATA = DATA_W'(AVMM_DEFAULT_RDATA),
    localparam int               LANES         = lane_cnt(DATA_W),
    localparam int               STAT_W        = (NUM_STATUS > 0) ? NUM_STATUS * DATA_W : 1
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic [ADDR_W-1:0]            avs_address,
    input  logic                         avs_read,
    input  logic                         avs_write,
    input  logic [DATA_W-1:0]            avs_writedata,
    input  logic [LANES-1:0]             avs_byteenable,
    output logic [DATA_W-1:0]            avs_readdata,
    output logic                         avs_readdatavalid,
    output logic                         avs_waitrequest,
    input  logic [STAT_W-1:0]            status_in,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [NUM_REGS-1:0]          wr_strobe
);

    localparam int IDX_W = idx_w(NUM_REGS + NUM_STATUS);

    logic [ADDR_W-3:0]  word_idx;
    logic [IDX_W-1:0]   word_lo;
    logic               hi_zero;
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]  reg_q  [NUM_REGS];
    logic [DATA_W-1:0]  stat_w [(NUM_STATUS > 0) ? NUM_STATUS : 1];
    logic [DATA_W-1:0]  rd_data;
    logic               unused_addr;

    assign word_idx        = avs_address[ADDR_W-1:2];
    assign word_lo         = word_idx[IDX_W-1:0];
    // Bits above the index width must be zero, so no upper address aliases a register.
    assign hi_zero         = (word_idx >> IDX_W) == '0;
    assign unused_addr     = ^avs_address[1:0];
    assign avs_waitrequest = 1'b0;

    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NUM_REGS; r++)
            wr_hit[r] = avs_write && hi_zero && (word_lo == IDX_W'(r));
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [7:0] lane_q;
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n)
                    lane_q <= RESET_VAL[l*8 +: 8];
                else if (wr_hit[r] && avs_byteenable[l])
                    lane_q <= avs_writedata[l*8 +: 8];
            end
            assign reg_q[r][l*8 +: 8] = lane_q;
        end
        assign regs_out[r*DATA_W +: DATA_W] = reg_q[r];
    end

    if (NUM_STATUS > 0) begin : g_stat
        for (genvar s = 0; s < NUM_STATUS; s++) begin : g_word
            assign stat_w[s] = status_in[s*DATA_W +: DATA_W];
        end
    end else begin : g_no_stat
        logic unused_status;
        assign unused_status = ^status_in;
        assign stat_w[0]     = '0;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) wr_strobe <= '0;
        else                wr_strobe <= wr_hit;
    end

    // Combinational mux sees pre-edge register values, giving read-before-write on collisions.
    always_comb begin
        rd_data = DEFAULT_RDATA;
        for (int r = 0; r < NUM_REGS; r++)
            if (hi_zero && word_lo == IDX_W'(r)) rd_data = reg_q[r];
        for (int s = 0; s < NUM_STATUS; s++)
            if (hi_zero && word_lo == IDX_W'(NUM_REGS + s)) rd_data = stat_w[s];
    end

    avmm_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .DATA_W  (DATA_W)
    ) u_rd_pipe (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .in_valid      (avs_read),
        .in_data       (rd_data),
        .out_valid     (avs_readdatavalid),
        .out_data      (avs_readdata)
    );

endmodule

// File: tb/tb_avmm_reg_bank.sv
// Scoreboard bench for avmm_reg_bank with four registers, two status words, latency 3.
module tb_avmm_reg_bank;

    localparam int L = 3;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n = 1'b0;
    logic [31:0]   avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [3:0]    avs_byteenable = '0;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic          avs_waitrequest;
    logic [63:0]   status_in = {32'hCAFEF00D, 32'h11112222};
    logic [127:0]  regs_out;
    logic [3:0]    wr_strobe;

    avmm_reg_bank #(
        .NUM_REGS     (4),
        .NUM_STATUS   (2),
        .DATA_W       (32),
        .ADDR_W       (32),
        .READ_LATENCY (L)
    ) dut (
        .clk_clk           (clk_clk),
        .reset_reset_n     (reset_reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_waitrequest   (avs_waitrequest),
        .status_in         (status_in),
        .regs_out          (regs_out),
        .wr_strobe         (wr_strobe)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every response must match the oldest expectation, in data and arrival cycle.
    exp_t e;
    always @(negedge clk_clk) begin
        if (reset_reset_n && avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rvalid", 128'(avs_readdata), 128'h1_0000_0000);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_data"}, 128'(avs_readdata), 128'(e.data));
                chk({e.name, "_cycle"}, 128'(cyc), 128'(e.due));
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp, input string name);
        @(negedge clk_clk);
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = addr;
        avs_writedata  = wdata;
        avs_byteenable = be;
        if (rd) exp_q.push_back('{exp, cyc + L, name});
    endtask

    task automatic idle();
        @(negedge clk_clk);
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_address    = '0;
        avs_writedata  = '0;
        avs_byteenable = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_clk);
        chk("rst_regs_out", regs_out, 128'h0);
        chk("rst_rvalid", 128'(avs_readdatavalid), 128'h0);
        chk("rst_rdata", 128'(avs_readdata), 128'h0);
        chk("rst_strobe", 128'(wr_strobe), 128'h0);
        chk("waitrequest", 128'(avs_waitrequest), 128'h0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;

        issue(1, 0, 32'h0C, 0, 4'h0, 32'h0000_0000, "rd_reg3_reset");
        idle();

        issue(0, 1, 32'h04, 32'h1234_5678, 4'b0101, 0, "");
        idle();
        chk("be_write_regs", regs_out, {32'h0, 32'h0, 32'h0034_0078, 32'h0});
        chk("be_write_strobe", 128'(wr_strobe), 128'h2);
        idle();
        chk("strobe_one_cycle", 128'(wr_strobe), 128'h0);
        issue(1, 0, 32'h04, 0, 4'h0, 32'h0034_0078, "rd_reg1");

        issue(0, 1, 32'h08, 32'hA5A5_A5A5, 4'hF, 0, "");
        issue(1, 0, 32'h08, 0, 4'h0, 32'hA5A5_A5A5, "rd_after_wr");
        idle();

        issue(0, 1, 32'h0C, 32'h7766_5544, 4'hF, 0, "");
        idle();
        issue(0, 1, 32'h0C, 32'hFFFF_FFFF, 4'h0, 0, "");
        idle();
        chk("be_zero_strobe", 128'(wr_strobe), 128'h8);
        chk("be_zero_hold", 128'(regs_out[127:96]), 128'h7766_5544);

        issue(1, 0, 32'h40, 0, 4'h0, 32'hDEAD_BEEF, "rd_unmapped_40");
        issue(1, 0, 32'h18, 0, 4'h0, 32'hDEAD_BEEF, "rd_unmapped_18");
        issue(1, 0, 32'h20, 0, 4'h0, 32'hDEAD_BEEF, "rd_alias_20");
        issue(1, 0, 32'h4000_0000, 0, 4'h0, 32'hDEAD_BEEF, "rd_alias_top");
        issue(0, 1, 32'h40, 32'hFFFF_FFFF, 4'hF, 0, "");
        idle();
        chk("wr_unmapped_strobe", 128'(wr_strobe), 128'h0);
        issue(0, 1, 32'h20, 32'hFFFF_FFFF, 4'hF, 0, "");
        idle();
        chk("wr_alias_strobe", 128'(wr_strobe), 128'h0);
        chk("wr_unmapped_regs", regs_out, {32'h7766_5544, 32'hA5A5_A5A5, 32'h0034_0078, 32'h0});

        issue(1, 0, 32'h14, 0, 4'h0, 32'hCAFE_F00D, "rd_status1");
        issue(1, 0, 32'h10, 0, 4'h0, 32'h1111_2222, "rd_status0");
        status_in[63:32] = 32'h0BAD_F00D;
        issue(1, 0, 32'h15, 0, 4'h0, 32'h0BAD_F00D, "rd_status1_new");
        issue(0, 1, 32'h14, 32'hFFFF_FFFF, 4'hF, 0, "");
        idle();
        chk("wr_status_strobe", 128'(wr_strobe), 128'h0);
        chk("wr_status_regs", regs_out, {32'h7766_5544, 32'hA5A5_A5A5, 32'h0034_0078, 32'h0});

        issue(1, 0, 32'h00, 0, 4'h0, 32'h0000_0000, "stream0");
        issue(1, 0, 32'h04, 0, 4'h0, 32'h0034_0078, "stream1");
        issue(1, 0, 32'h08, 0, 4'h0, 32'hA5A5_A5A5, "stream2");
        issue(1, 0, 32'h0C, 0, 4'h0, 32'h7766_5544, "stream3");
        idle();
        repeat (L + 1) @(negedge clk_clk);

        issue(1, 1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, "collide_old");
        idle();
        chk("collide_reg0", 128'(regs_out[31:0]), 128'hFFFF_FFFF);
        chk("collide_strobe", 128'(wr_strobe), 128'h1);
        issue(1, 0, 32'h00, 0, 4'h0, 32'hFFFF_FFFF, "rd_reg0_new");
        idle();
        repeat (L + 2) @(negedge clk_clk);
        chk("queue_drained", 128'(exp_q.size()), 128'h0);
        chk("rdata_hold", 128'(avs_readdata), 128'hFFFF_FFFF);
        chk("rvalid_idle", 128'(avs_readdatavalid), 128'h0);

        @(negedge clk_clk);
        avs_read    = 1'b1;
        avs_address = 32'h04;
        @(negedge clk_clk);
        avs_read      = 1'b0;
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        chk("abort_regs_reset", regs_out, 128'h0);
        chk("abort_rdata_reset", 128'(avs_readdata), 128'h0);
        reset_reset_n = 1'b1;
        for (int i = 0; i < L + 2; i++) begin
            @(negedge clk_clk);
            chk("abort_no_rvalid", 128'(avs_readdatavalid), 128'h0);
        end
        chk("final_queue_empty", 128'(exp_q.size()), 128'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
